// File: rtl/darkio_regs.sv
// darksocv I/O register slave: board info, LED/GPIO, reloadable timer and W1C interrupt pending.
// Optional macro DARKIO_EXTIRQ_EN enables rising-edge capture of IRQ_IN into PEND[6:0].
module darkio_regs #(
  parameter logic [7:0]  BOARD_ID    = 8'd0,
  parameter int unsigned BOARD_CK    = 50000000,
  parameter logic [31:0] TIMER_RESET = 32'(BOARD_CK / 1000000 - 1)
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        EN,
  input  logic        RE,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        RACK,
  output logic        WACK,
  input  logic [6:0]  IRQ_IN,
  output logic [15:0] LED,
  output logic [15:0] GPIO,
  output logic        IRQ,
  output logic        dbg_state
);

  localparam logic [7:0] CK_MHZ = 8'(BOARD_CK / 1000000);
  localparam logic [7:0] CK_KHZ = 8'((BOARD_CK / 10000) % 100);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rd_go;
  logic        wr_go;
  logic        wr_w0;
  logic        wr_w2;
  logic        wr_w3;
  logic [31:0] rdata;
  logic [31:0] io_nxt;
  logic [31:0] rld_nxt;
  logic [31:0] tmr_rld;
  logic [31:0] tmr_cnt;
  logic        tmr_exp;
  logic [7:0]  pend;
  logic [7:0]  pend_set;
  logic [7:0]  pend_clr;
  logic [6:0]  ext_rise;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Handshake: a request EN && (RE || WE) is accepted only in IDLE and
  // performed at that edge; RACK (read, wins over write) or WACK pulses for
  // exactly the next cycle while the FSM sits in ACK, where requests are ignored.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN && (RE || WE)) begin
          state_nxt = S_ACK;
          rd_go     = RE;
          wr_go     = !RE && WE;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  assign wr_w0 = wr_go && (ADDR[3:2] == 2'd0);
  assign wr_w2 = wr_go && (ADDR[3:2] == 2'd2);
  assign wr_w3 = wr_go && (ADDR[3:2] == 2'd3);

  always_comb begin
    rdata = 32'd0;
    case (ADDR[3:2])
      2'd0:    rdata = {pend, CK_KHZ, CK_MHZ, BOARD_ID};
      2'd1:    rdata = tmr_cnt;
      2'd2:    rdata = {GPIO, LED};
      2'd3:    rdata = tmr_rld;
      default: rdata = 32'd0;
    endcase
  end

  assign io_nxt  = be_merge({GPIO, LED}, DATAI, BE);
  assign rld_nxt = be_merge(tmr_rld, DATAI, BE);

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      DATAO <= 32'd0;
      RACK  <= 1'b0;
      WACK  <= 1'b0;
    end else begin
      RACK <= rd_go;
      WACK <= wr_go;
      if (rd_go) DATAO <= rdata;
    end
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      LED  <= 16'd0;
      GPIO <= 16'd0;
    end else if (wr_w2) begin
      GPIO <= io_nxt[31:16];
      LED  <= io_nxt[15:0];
    end
  end

  // A reload of 0 freezes the counter; 0 otherwise always reloads, so no underflow.
  assign tmr_exp = (tmr_rld != 32'd0) && (tmr_cnt == 32'd0);

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      tmr_rld <= TIMER_RESET;
      tmr_cnt <= TIMER_RESET;
    end else if (wr_w3) begin
      tmr_rld <= rld_nxt;
      tmr_cnt <= rld_nxt;
    end else if (tmr_rld != 32'd0) begin
      if (tmr_cnt == 32'd0) tmr_cnt <= tmr_rld;
      else                  tmr_cnt <= tmr_cnt - 32'd1;
    end
  end

`ifdef DARKIO_EXTIRQ_EN
  logic [6:0] irq_in_q;

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) irq_in_q <= 7'd0;
    else       irq_in_q <= IRQ_IN;
  end

  assign ext_rise = IRQ_IN & ~irq_in_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^IRQ_IN;
  assign ext_rise      = 7'd0;
`endif

  logic unused_bus;
  assign unused_bus = ^{ADDR[31:4], ADDR[1:0], DATAI[23:0]};

  assign pend_set = {tmr_exp, ext_rise};
  assign pend_clr = (wr_w0 && BE[3]) ? DATAI[31:24] : 8'd0;

  // Set is OR-ed after the clear so a same-cycle event is never lost.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      pend <= 8'd0;
      IRQ  <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      IRQ  <= |pend;
    end
  end

endmodule

// File: tb/tb_darkio_regs.sv
// Directed bench for darkio_regs: register map, byte enables, timer/PEND timing, held requests, reset.
// Expectations for PEND[6:0] follow DARKIO_EXTIRQ_EN when the bench is built with that macro.
module tb_darkio_regs;

  logic        XCLK;
  logic        XRES;
  logic        EN;
  logic        RE;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic [31:0] DATAI;
  logic [31:0] DATAO;
  logic        RACK;
  logic        WACK;
  logic [6:0]  IRQ_IN;
  logic [15:0] LED;
  logic [15:0] GPIO;
  logic        IRQ;
  logic        dbg_state;

  int checks;
  int failures;

  localparam logic [31:0] A_W0 = 32'h8000_0000;
  localparam logic [31:0] A_W1 = 32'h8000_0004;
  localparam logic [31:0] A_W2 = 32'h8000_0008;
  localparam logic [31:0] A_W3 = 32'h8000_000C;

  darkio_regs #(
    .BOARD_ID (8'h5A),
    .BOARD_CK (50000000)
  ) dut (
    .XCLK      (XCLK),
    .XRES      (XRES),
    .EN        (EN),
    .RE        (RE),
    .WE        (WE),
    .BE        (BE),
    .ADDR      (ADDR),
    .DATAI     (DATAI),
    .DATAO     (DATAO),
    .RACK      (RACK),
    .WACK      (WACK),
    .IRQ_IN    (IRQ_IN),
    .LED       (LED),
    .GPIO      (GPIO),
    .IRQ       (IRQ),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers: called just after a rising edge; request sampled at the next edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    EN = 1'b1; WE = 1'b1; ADDR = addr; DATAI = data; BE = be;
    @(posedge XCLK); #1;
    EN = 1'b0; WE = 1'b0;
    chk("wack", 32'(WACK), 32'd1);
    @(posedge XCLK); #1;
  endtask

  task automatic bus_read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    EN = 1'b1; RE = 1'b1; ADDR = addr;
    @(posedge XCLK); #1;
    EN = 1'b0; RE = 1'b0;
    chk("rack", 32'(RACK), 32'd1);
    chk(tag, DATAO, exp);
    @(posedge XCLK); #1;
  endtask

  task automatic step_chk_irq(input string tag, input logic exp);
    @(posedge XCLK); #1;
    chk(tag, 32'(IRQ), 32'(exp));
  endtask

  logic [31:0] exp_ext;
  int          rack_cnt;

  initial begin
    checks = 0; failures = 0;
    XRES = 1'b0; EN = 1'b0; RE = 1'b0; WE = 1'b0;
    BE = 4'd0; ADDR = 32'd0; DATAI = 32'd0; IRQ_IN = 7'd0;

    #12;
    chk("rst_datao", DATAO, 32'd0);
    chk("rst_rack", 32'(RACK), 32'd0);
    chk("rst_wack", 32'(WACK), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_gpio", 32'(GPIO), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    #11 XRES = 1'b1;
    @(posedge XCLK); #1;

    bus_read_chk("w0_info", A_W0, 32'h0000_325A);
    bus_read_chk("w3_reset", A_W3, 32'd49);

    bus_write(A_W2, 32'hAAAA_5555, 4'b0011);
    chk("be_lo_led", 32'(LED), 32'h5555);
    chk("be_lo_gpio", 32'(GPIO), 32'h0000);
    bus_write(A_W2, 32'hAAAA_1234, 4'b1100);
    chk("be_hi_gpio", 32'(GPIO), 32'hAAAA);
    chk("be_hi_led", 32'(LED), 32'h5555);
    bus_read_chk("w2_rdback", A_W2, 32'hAAAA_5555);

    // read and write together: read wins, write dropped
    EN = 1'b1; RE = 1'b1; WE = 1'b1; ADDR = A_W2; DATAI = 32'hFFFF_FFFF; BE = 4'hF;
    @(posedge XCLK); #1;
    EN = 1'b0; RE = 1'b0; WE = 1'b0;
    chk("rw_rack", 32'(RACK), 32'd1);
    chk("rw_wack", 32'(WACK), 32'd0);
    chk("rw_datao", DATAO, 32'hAAAA_5555);
    @(posedge XCLK); #1;
    chk("rw_led", 32'(LED), 32'h5555);
    chk("rw_gpio", 32'(GPIO), 32'hAAAA);

    // held request over 6 edges
    rack_cnt = 0;
    EN = 1'b1; RE = 1'b1; ADDR = A_W0;
    for (int i = 0; i < 6; i++) begin
      @(posedge XCLK); #1;
      rack_cnt += int'(RACK);
    end
    EN = 1'b0; RE = 1'b0;
    chk("held_racks", 32'(rack_cnt), 32'd3);
    @(posedge XCLK); #1;

    // timer: reload 4 at edge N, clear at N+2, expiry at N+5, IRQ at N+6
    bus_write(A_W3, 32'd4, 4'hF);
    bus_write(A_W0, 32'h8000_0000, 4'b1000);
    chk("irq_clr1", 32'(IRQ), 32'd0);
    step_chk_irq("irq_n4", 1'b0);
    step_chk_irq("irq_n5", 1'b0);
    step_chk_irq("irq_exp1", 1'b1);
    // clear lands on the N+10 expiry edge: set must win
    repeat (3) @(posedge XCLK);
    #1;
    bus_write(A_W0, 32'h8000_0000, 4'b1000);
    chk("collision", 32'(IRQ), 32'd1);
    bus_write(A_W0, 32'h8000_0000, 4'b1000);
    chk("irq_clr2", 32'(IRQ), 32'd0);
    step_chk_irq("irq_n14", 1'b0);
    step_chk_irq("irq_n15", 1'b0);
    step_chk_irq("irq_exp3", 1'b1);
    bus_read_chk("w0_pend7", A_W0, 32'h8000_325A);
    bus_write(A_W3, 32'd0, 4'hF);
    bus_write(A_W0, 32'h8000_0000, 4'b1000);
    repeat (20) @(posedge XCLK);
    #1;
    chk("no_expiry", 32'(IRQ), 32'd0);
    bus_read_chk("w1_frozen", A_W1, 32'd0);

    // external interrupt line 2, then held high across a clear
`ifdef DARKIO_EXTIRQ_EN
    exp_ext = 32'h0400_325A;
`else
    exp_ext = 32'h0000_325A;
`endif
    IRQ_IN = 7'h04;
    @(posedge XCLK); #1;
    bus_read_chk("ext_pend", A_W0, exp_ext);
    bus_write(A_W0, 32'h0400_0000, 4'b1000);
    bus_read_chk("ext_held", A_W0, 32'h0000_325A);
    IRQ_IN = 7'h00;

    bus_write(A_W1, 32'h0000_1234, 4'hF);
    bus_read_chk("w1_ro", A_W1, 32'd0);

    bus_write(A_W3, 32'hDEAD_BEEF, 4'hF);
    bus_write(A_W3, 32'h1122_3344, 4'b0101);
    bus_read_chk("w3_be", A_W3, 32'hDE22_BE44);

    // reset while in ACK
    EN = 1'b1; RE = 1'b1; ADDR = A_W0;
    @(posedge XCLK); #1;
    EN = 1'b0; RE = 1'b0;
    chk("pre_rst_state", 32'(dbg_state), 32'd1);
    chk("pre_rst_rack", 32'(RACK), 32'd1);
    XRES = 1'b0;
    #1;
    chk("mid_rst_rack", 32'(RACK), 32'd0);
    chk("mid_rst_led", 32'(LED), 32'd0);
    chk("mid_rst_gpio", 32'(GPIO), 32'd0);
    chk("mid_rst_datao", DATAO, 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge XCLK);
    XRES = 1'b1;
    @(posedge XCLK); #1;
    bus_read_chk("post_rst_w3", A_W3, 32'd49);
    bus_read_chk("post_rst_w2", A_W2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/darkio_regs.md
# darkio_regs

Memory-mapped I/O register slave for the darksocv SoC, sitting downstream of the `darkmm` memory map on the I/O window (address bit 31 set). It takes the board-info, LED/GPIO, timer and interrupt-request logic out of the top level and puts it behind the same EN/RE/WE/RACK/WACK handshake used by the ROM, flash and RAM slaves. It has one access state machine, a reloadable down-counter timer, and a write-1-to-clear interrupt pending register.

## Interface
Parameters:
- `BOARD_ID`, default 0: 8-bit board identifier.
- `BOARD_CK`, default 50000000: board clock in Hz.
- `TIMER_RESET`, default `BOARD_CK/1000000-1`: reset value of the timer reload, giving a 1 MHz tick.

Ports:
- `XCLK`, in, 1: the single clock. Everything is on its rising edge.
- `XRES`, in, 1: reset, asynchronous and active-low.
- `EN`, in, 1: slave select from `darkmm`.
- `RE`, in, 1: read request.
- `WE`, in, 1: write request.
- `BE`, in, 4: byte enables for writes.
- `ADDR`, in, 32: byte address. Only `ADDR[3:2]` is decoded.
- `DATAI`, in, 32: write data.
- `DATAO`, out, 32: read data, registered.
- `RACK`, out, 1: read acknowledge, a one-cycle pulse.
- `WACK`, out, 1: write acknowledge, a one-cycle pulse.
- `IRQ_IN`, in, 7: external interrupt lines, level inputs synchronous to `XCLK`.
- `LED`, out, 16: LED register.
- `GPIO`, out, 16: GPIO output register.
- `IRQ`, out, 1: OR of all pending interrupt bits.

## Operation
Register map, selected by `ADDR[3:2]`:
- **Word 0 (read):** `{PEND[7:0], CK_KHZ, CK_MHZ, BOARD_ID}`.
  - `CK_MHZ = BOARD_CK/1000000` (8-bit).
  - `CK_KHZ = (BOARD_CK/10000)%100`.
  - **Write:** each `DATAI[24+n]` bit set clears `PEND[n]` (write-1-to-clear). Acts only when `BE[3]=1`.
- **Word 1:** current timer counter. Read-only; writes are acknowledged and ignored.
- **Word 2:** `{GPIO, LED}`, read/write, bytewise per `BE`.
- **Word 3:** timer reload, 32-bit, read/write, bytewise per `BE`.
  - Any write also loads the counter with the resulting reload value.

Access FSM:
- States are IDLE and ACK.
- IDLE → ACK when `EN && (RE || WE)`:
  - The access is performed at that edge.
  - `RACK` is set if `RE`, otherwise `WACK` is set if `WE`.
  - If both `RE` and `WE` are high, the access is treated as a read and the write is dropped.
- ACK → IDLE unconditionally. Acks clear and no request is sampled in ACK.
  - A request held high is therefore serviced once every 2 cycles.
- `DATAO` is updated only on reads and holds its value otherwise.

Timer:
- Counter width is 32 bits.
- If reload is 0, the counter holds and never expires.
- Otherwise, each cycle:
  - counter == 0: counter ← reload, and an expiry pulse is generated.
  - counter != 0: counter ← counter−1.
- Period is reload+1 cycles.

Pending register `PEND[7:0]`:
- Bit 7 is set by timer expiry.
- Bits 6:0 are set on a rising edge of `IRQ_IN[n]` (see Configuration).
- If a set and a clear of the same bit happen in the same cycle, set wins.
- `IRQ = |PEND`, registered.

## Timing
- **Reset values:** `DATAO=0`, `RACK=0`, `WACK=0`, `LED=0`, `GPIO=0`, `IRQ=0`, `PEND=0`, reload `=TIMER_RESET`, counter `=TIMER_RESET`, FSM = IDLE, `IRQ_IN` edge history = 0.
- **Read latency:** `EN&&RE` sampled at edge N → `RACK=1` and `DATAO` valid during cycle N+1 → `RACK=0` at N+2.
- **Write:** the register updates at edge N, `WACK=1` during cycle N+1, and a readback issued at N+2 returns the new value.
- **PEND:** an expiry or edge at edge N sets `PEND` at N. `IRQ` rises at N+1.
- **Reset mid-access:** when `XRES` falls, all outputs return to reset values immediately and any in-flight ack is lost. The master must retry.
- **Wrap-around:** the counter never underflows, because 0 always reloads.

## Configuration
- **Macro `DARKIO_EXTIRQ_EN` defined:**
  - `IRQ_IN` is registered once for edge detection.
  - A 0→1 transition on `IRQ_IN[n]` sets `PEND[n]` one cycle after the input rises.
- **Macro `DARKIO_EXTIRQ_EN` undefined:**
  - `IRQ_IN` is ignored.
  - `PEND[6:0]` reads as 0 permanently.
  - Only the timer can raise `IRQ`.

## Test plan
- **Reset values:** release reset with `BOARD_ID=8'h5A`, `BOARD_CK=50000000`, then read word 0 → `RACK` one cycle later, `DATAO=32'h0000325A`. Read word 3 → `32'd49`.
- **Byte-enable write:** write word 2 with `DATAI=32'hAAAA5555`, `BE=4'b0011` → `WACK` pulse, `LED=16'h5555`, `GPIO=16'h0000`. Then write `BE=4'b1100` → `GPIO=16'hAAAA`, `LED` unchanged.
- **Timer and ack:** write word 3 = 4 → `PEND[7]` sets after 5 cycles and `IRQ=1` the next cycle. Write word 0 `DATAI=32'h80000000`, `BE=4'b1000` → `PEND[7]=0`, `IRQ=0`. `PEND[7]` sets again 5 cycles after the previous expiry. Write reload 0 → no further expiries.
- **Set/clear collision:** schedule the clear write at the same edge as a timer expiry → `PEND[7]` remains 1.
- **External IRQ:** with `DARKIO_EXTIRQ_EN`, pulse `IRQ_IN[2]` high → `PEND` = `8'h04`. Holding it high does not re-set `PEND[2]` after a clear. Without the macro, `PEND[6:0]` stays 0.
- **Held request and reset:**
  - Hold `EN&&RE` for 6 cycles → exactly 3 `RACK` pulses.
  - Assert `XRES` low during the ACK state → `RACK=0` immediately and `LED=0`.
